// File: rtl/fp16_normalize_round_pkg.sv
// Shared constants and the stage-1 record for the fp16 normalise/round stage.
package fp16_normalize_round_pkg;
  localparam int unsigned EXP_W  = 5;
  localparam int unsigned FRAC_W = 10;
  localparam int unsigned BIAS   = 15;
  localparam int unsigned MANT_W = FRAC_W + 5;
  localparam int unsigned IEXP_W = EXP_W + 2;

  localparam logic [EXP_W-1:0] EXP_MAX = 5'h1F;
  localparam logic [15:0]      INF_POS = 16'h7C00;
  localparam logic [15:0]      QNAN    = 16'h7E00;

  // Saturation threshold expressed in the signed internal exponent domain.
  localparam logic signed [IEXP_W-1:0] EXP_OVF = signed'({2'b00, EXP_MAX});

  typedef struct packed {
    logic                     sign;
    logic signed [IEXP_W-1:0] expo;
    logic [FRAC_W-1:0]        frac;
    logic                     g;
    logic                     r;
    logic                     s;
    logic                     special;
    logic                     zero;
    logic                     uf;
  } s1_t;
endpackage

// File: rtl/fp16_normalize_round_if.sv
// Upstream sum / downstream result handshake bundle.
interface fp16_normalize_round_if;
  import fp16_normalize_round_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic              in_sign;
  logic [EXP_W-1:0]  in_exp;
  logic [MANT_W-1:0] in_mant;
  logic              in_special;
  logic [15:0]       in_special_val;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_result;
  logic              out_overflow;
  logic              out_underflow;
  logic              out_inexact;

  modport master (
    output in_valid, in_sign, in_exp, in_mant, in_special, in_special_val, out_ready,
    input  in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );

  modport slave (
    input  in_valid, in_sign, in_exp, in_mant, in_special, in_special_val, out_ready,
    output in_ready, out_valid, out_result, out_overflow, out_underflow, out_inexact
  );
endinterface

// File: rtl/fp16_normalize_round_lzc.sv
// Combinational 14-bit leading-zero counter; all-zero input yields 14.
module fp16_lzc (
  input  logic [13:0] i_data,
  output logic [3:0]  o_count
);
  logic w_found;

  // Scan from the MSB and latch the first set position.
  always_comb begin
    o_count = 4'd14;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 14; i++) begin
      if (!w_found && i_data[13 - i]) begin
        o_count = 4'(i);
        w_found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/fp16_normalize_round.sv
// fp16 post-add stage: normalise (stage 1), round-to-nearest-even and
// saturate/flush (stage 2 = output register), 2-deep valid/ready pipeline.
module fp16_normalize_round
  import fp16_normalize_round_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  fp16_normalize_round_if.slave bus
);
  logic                     r_s1_valid;
  s1_t                      r_s1;
  logic [15:0]              r_s1_sval;
  logic                     r_out_valid;
  logic [15:0]              r_out_result;
  logic                     r_out_ovf;
  logic                     r_out_udf;
  logic                     r_out_inx;

  logic                     w_s1_load;
  logic                     w_s2_load;
  logic [3:0]               w_lz;
  logic [12:0]              w_shl;
  logic signed [IEXP_W-1:0] w_exp_in;
  logic signed [IEXP_W-1:0] w_exp_n;
  s1_t                      w_s1;

  logic                     w_inc;
  logic [FRAC_W:0]          w_rnd;
  logic signed [IEXP_W-1:0] w_exp_r;
  logic [15:0]              w_res;
  logic                     w_ovf;
  logic                     w_udf;
  logic                     w_inx;

  assign w_s2_load    = !r_out_valid | bus.out_ready;
  assign w_s1_load    = !r_s1_valid | w_s2_load;
  assign bus.in_ready = rst_n & w_s1_load;

  fp16_lzc u_lzc (
    .i_data  (bus.in_mant[13:0]),
    .o_count (w_lz)
  );

  // The hidden bit lands at [13] after the shift and is implicit, so only [12:0] is kept.
  assign w_shl    = 13'(bus.in_mant[13:0] << w_lz);
  assign w_exp_in = signed'({2'b00, bus.in_exp});

  // Stage 1: classify the sum and normalise the hidden bit into position.
  always_comb begin
    w_s1      = '0;
    w_exp_n   = w_exp_in;
    w_s1.sign = bus.in_sign;
    if (bus.in_special) begin
      w_s1.special = 1'b1;
    end else if (bus.in_mant == '0) begin
      w_s1.zero = 1'b1;
    end else if (bus.in_mant[14]) begin
      w_exp_n                        = w_exp_in + 7'sd1;
      {w_s1.frac, w_s1.g, w_s1.r}    = bus.in_mant[13:2];
      w_s1.s                         = |bus.in_mant[1:0];
    end else begin
      w_exp_n                              = w_exp_in - signed'({3'b000, w_lz});
      {w_s1.frac, w_s1.g, w_s1.r, w_s1.s}  = w_shl;
    end
    w_s1.expo = w_exp_n;
    w_s1.uf   = !bus.in_special && (bus.in_mant != '0) && (w_exp_n <= 7'sd0);
  end

  // Stage-1 register: loads when empty or when stage 2 takes its contents.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1       <= '0;
      r_s1_sval  <= '0;
    end else if (w_s1_load) begin
      r_s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        r_s1      <= w_s1;
        r_s1_sval <= bus.in_special_val;
      end
    end
  end

  // Stage 2: RNE increment, then select special / zero / flush / saturate / normal.
  always_comb begin
    w_inc   = r_s1.g & (r_s1.r | r_s1.s | r_s1.frac[0]);
    w_rnd   = {1'b0, r_s1.frac} + {{FRAC_W{1'b0}}, w_inc};
    w_exp_r = r_s1.expo + (w_rnd[FRAC_W] ? 7'sd1 : 7'sd0);
    w_res   = '0;
    w_ovf   = 1'b0;
    w_udf   = 1'b0;
    w_inx   = 1'b0;
    if (r_s1.special) begin
      w_res = r_s1_sval;
    end else if (r_s1.zero) begin
      w_res = {r_s1.sign, 15'h0};
    end else if (r_s1.uf) begin
      w_res = {r_s1.sign, 15'h0};
      w_udf = 1'b1;
      w_inx = 1'b1;
    end else if (w_exp_r >= EXP_OVF) begin
      w_res = {r_s1.sign, EXP_MAX, {FRAC_W{1'b0}}};
      w_ovf = 1'b1;
      w_inx = 1'b1;
    end else begin
      w_res = {r_s1.sign, w_exp_r[EXP_W-1:0], w_rnd[FRAC_W-1:0]};
      w_inx = r_s1.g | r_s1.r | r_s1.s;
    end
  end

  // Output register: holds while the consumer stalls, refills from stage 1 otherwise.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_ovf    <= 1'b0;
      r_out_udf    <= 1'b0;
      r_out_inx    <= 1'b0;
    end else if (w_s2_load) begin
      r_out_valid <= r_s1_valid;
      if (r_s1_valid) begin
        r_out_result <= w_res;
        r_out_ovf    <= w_ovf;
        r_out_udf    <= w_udf;
        r_out_inx    <= w_inx;
      end
    end
  end

  assign bus.out_valid     = r_out_valid;
  assign bus.out_result    = r_out_result;
  assign bus.out_overflow  = r_out_ovf;
  assign bus.out_underflow = r_out_udf;
  assign bus.out_inexact   = r_out_inx;
endmodule

// File: tb/tb_fp16_normalize_round.sv
// Bench for fp16_normalize_round: directed vector table, backpressure and
// reset sequences, then randomized traffic against an arithmetic reference.
module tb_fp16_normalize_round;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_pass;
  logic mon_en;
  logic [18:0] q_exp[$];
  logic [18:0] mon_e;

  fp16_normalize_round_if bus ();

  fp16_normalize_round dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        sg;
    logic [4:0]  ex;
    logic [14:0] mt;
    logic        sp;
    logic [15:0] sv;
    logic [15:0] res;
    logic        ov;
    logic        uf;
    logic        nx;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
  endtask

  // Reference: value = mant * 2^(exp-28); round the significand to 11 bits RNE.
  function automatic logic [18:0] ref_model(input logic sg, input logic [4:0] ex,
                                            input logic [14:0] mt, input logic sp,
                                            input logic [15:0] sv);
    int p;
    int e;
    int sh;
    int unsigned keep;
    int unsigned rem;
    int unsigned half;
    logic nx;
    if (sp) return {3'b000, sv};
    if (mt == 15'h0) return {3'b000, sg, 15'h0};
    p = 14;
    while (!mt[p]) p--;
    e = int'(ex) + p - 13;
    if (e <= 0) return {3'b011, sg, 15'h0};
    if (p > 10) begin
      sh   = p - 10;
      keep = mt >> sh;
      rem  = mt & ((1 << sh) - 1);
      half = 1 << (sh - 1);
    end else begin
      keep = mt << (10 - p);
      rem  = 0;
      half = 1;
    end
    nx = (rem != 0);
    if (rem > half || (rem == half && keep[0])) keep++;
    if (keep == 2048) begin
      keep = 1024;
      e++;
    end
    if (e >= 31) return {3'b101, sg, 5'h1F, 10'h0};
    return {2'b00, nx, sg, 5'(e), 10'(keep)};
  endfunction

  task automatic drive(input vec_t v);
    bus.in_valid       = 1'b1;
    bus.in_sign        = v.sg;
    bus.in_exp         = v.ex;
    bus.in_mant        = v.mt;
    bus.in_special     = v.sp;
    bus.in_special_val = v.sv;
  endtask

  // Scoreboard: predict on accept, compare on drain; both sampled mid-cycle.
  always @(negedge clk) begin
    if (mon_en && rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (q_exp.size() == 0) begin
          check("rnd_unexpected_output", 32'd1, 32'd0);
        end else begin
          mon_e = q_exp.pop_front();
          check("rnd_result", {13'd0, bus.out_overflow, bus.out_underflow, bus.out_inexact,
                               bus.out_result}, {13'd0, mon_e});
        end
      end
      if (bus.in_valid && bus.in_ready)
        q_exp.push_back(ref_model(bus.in_sign, bus.in_exp, bus.in_mant, bus.in_special,
                                  bus.in_special_val));
    end
  end

  initial begin
    int   lat;
    logic got;
    int   mode;
    n_checks = 0;
    n_pass   = 0;
    mon_en   = 1'b0;
    rst_n    = 1'b0;
    bus.in_valid = 1'b0; bus.in_sign = 1'b0; bus.in_exp = '0; bus.in_mant = '0;
    bus.in_special = 1'b0; bus.in_special_val = '0; bus.out_ready = 1'b0;

    tbl[0]  = '{1'b0, 5'd14, 15'h3000, 1'b0, 16'h0,    16'h3A00, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b0, 5'd15, 15'h4000, 1'b0, 16'h0,    16'h4000, 1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 5'd14, 15'h0400, 1'b0, 16'h0,    16'h2C00, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 5'd15, 15'h200C, 1'b0, 16'h0,    16'h3C02, 1'b0, 1'b0, 1'b1};
    tbl[4]  = '{1'b0, 5'd15, 15'h2004, 1'b0, 16'h0,    16'h3C00, 1'b0, 1'b0, 1'b1};
    tbl[5]  = '{1'b0, 5'd30, 15'h3FFF, 1'b0, 16'h0,    16'h7C00, 1'b1, 1'b0, 1'b1};
    tbl[6]  = '{1'b1, 5'd1,  15'h0400, 1'b0, 16'h0,    16'h8000, 1'b0, 1'b1, 1'b1};
    tbl[7]  = '{1'b0, 5'd0,  15'h0000, 1'b1, 16'h7E00, 16'h7E00, 1'b0, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 5'd5,  15'h0000, 1'b0, 16'h0,    16'h8000, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 5'd31, 15'h2000, 1'b0, 16'h0,    16'h7C00, 1'b1, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 5'd1,  15'h2000, 1'b0, 16'h0,    16'h0400, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 5'd0,  15'h2000, 1'b0, 16'h0,    16'h0000, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 5'd30, 15'h3FF8, 1'b0, 16'h0,    16'h7BFF, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 5'd15, 15'h4001, 1'b0, 16'h0,    16'h4000, 1'b0, 1'b0, 1'b1};
    tbl[14] = '{1'b0, 5'd15, 15'h3FFC, 1'b0, 16'h0,    16'h4000, 1'b0, 1'b0, 1'b1};

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    check("rst_out_result", 32'(bus.out_result), 32'd0);
    check("rst_flags", {29'd0, bus.out_overflow, bus.out_underflow, bus.out_inexact}, 32'd0);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Directed table, one transaction at a time.
    for (int i = 0; i < 15; i++) begin
      drive(tbl[i]);
      lat = 0;
      got = 1'b0;
      while (lat < 8 && !got) begin
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat++;
        if (bus.out_valid) got = 1'b1;
      end
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd2);
      check($sformatf("vec%0d_result", i), 32'(bus.out_result), 32'(tbl[i].res));
      check($sformatf("vec%0d_flags", i),
            {29'd0, bus.out_overflow, bus.out_underflow, bus.out_inexact},
            {29'd0, tbl[i].ov, tbl[i].uf, tbl[i].nx});
    end
    @(posedge clk);
    #1;

    // Backpressure: three back-to-back inputs with the consumer stalled.
    bus.out_ready = 1'b0;
    drive(tbl[0]);
    #1 check("bp_ready_a", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    drive(tbl[1]);
    #1 check("bp_ready_b", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    drive(tbl[2]);
    #1 check("bp_ready_c_blocked", 32'(bus.in_ready), 32'd0);
    check("bp_out_valid", 32'(bus.out_valid), 32'd1);
    check("bp_out_a", 32'(bus.out_result), 32'(tbl[0].res));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #2;
      check($sformatf("bp_hold_ready%0d", k), 32'(bus.in_ready), 32'd0);
      check($sformatf("bp_hold_result%0d", k), 32'(bus.out_result), 32'(tbl[0].res));
    end
    bus.out_ready = 1'b1;
    #1 check("bp_release_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    check("bp_drain_b_valid", 32'(bus.out_valid), 32'd1);
    check("bp_drain_b", 32'(bus.out_result), 32'(tbl[1].res));
    @(posedge clk); #1;
    check("bp_drain_c_valid", 32'(bus.out_valid), 32'd1);
    check("bp_drain_c", 32'(bus.out_result), 32'(tbl[2].res));
    @(posedge clk); #1;
    check("bp_empty", 32'(bus.out_valid), 32'd0);

    // Reset mid-stream discards everything in flight.
    for (int k = 0; k < 3; k++) begin
      drive(tbl[k + 3]);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1 check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
    rst_n = 1'b1;
    bus.in_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check($sformatf("midrst_no_stale%0d", k), 32'(bus.out_valid), 32'd0);
    end

    // Randomized traffic with random backpressure.
    mon_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      @(posedge clk); #1;
      bus.out_ready  = ($urandom_range(0, 3) != 0);
      bus.in_valid   = ($urandom_range(0, 3) != 0);
      bus.in_sign    = 1'($urandom_range(0, 1));
      bus.in_exp     = 5'($urandom_range(0, 31));
      bus.in_special = ($urandom_range(0, 15) == 0);
      bus.in_special_val = 16'($urandom);
      mode = int'($urandom_range(0, 4));
      case (mode)
        0:       bus.in_mant = 15'($urandom);
        1:       bus.in_mant = 15'(32'd1 << $urandom_range(0, 14)) | 15'($urandom_range(0, 3));
        2:       bus.in_mant = 15'h0;
        3:       bus.in_mant = 15'h4000 | 15'($urandom);
        default: bus.in_mant = 15'($urandom_range(0, 16383));
      endcase
    end
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    lat = 0;
    while (lat < 20 && q_exp.size() != 0) begin
      @(posedge clk); #1;
      lat++;
    end
    check("rnd_drained", 32'(q_exp.size()), 32'd0);
    mon_en = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
